// File: rtl/seg_scan_mux.sv
// ============================================================================
//  Module      : seg_scan_mux
//  Description : Time-multiplexing scanner for a common-anode multi-digit
//                seven-segment display. Walks one digit slot at a time with a
//                dark guard interval at the start of each slot, and swaps in
//                new display data only at frame boundaries so digits never tear.
//                Optional macro LEADING_ZERO_BLANK_EN blanks leading zeros
//                (digit 0 is never blanked) when data enters the display register.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg_scan_mux #(
    parameter int NUM_DIGITS = 4,
    parameter int PRESCALE   = 100000,
    parameter int GUARD      = 2000
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [4*NUM_DIGITS-1:0]       digits_in,
    input  logic [NUM_DIGITS-1:0]         dp_in,
    input  logic                          load,
    output logic [3:0]                    bcd_out,
    output logic [NUM_DIGITS-1:0]         an,
    output logic                          dp_n,
    output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
    output logic                          frame_done
);

    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam int CNT_W = $clog2(PRESCALE);
    localparam int DIG_W = 4 * NUM_DIGITS;

    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(PRESCALE - 1);
    localparam logic [CNT_W-1:0] CNT_GRD  = CNT_W'(GUARD);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [DIG_W-1:0] ALL_BLANK = {DIG_W{1'b1}};

    // Scan state
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;

    // Double-buffered display data
    logic [DIG_W-1:0]      pend_dig_q, pend_dig_d;
    logic [NUM_DIGITS-1:0] pend_dp_q, pend_dp_d;
    logic                  pend_valid_q, pend_valid_d;
    logic [DIG_W-1:0]      disp_dig_q, disp_dig_d;
    logic [NUM_DIGITS-1:0] disp_dp_q, disp_dp_d;

    // Registered display drive
    logic [3:0]            bcd_q, bcd_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic                  dp_n_q, dp_n_d;

    logic                  slot_end;
    logic                  frame_end;

    // Leading-zero suppression applied as data enters the display register;
    // a run of 0/blank digits from the top is blanked, digit 0 always shown.
    function automatic logic [DIG_W-1:0] lz_blank(input logic [DIG_W-1:0] d);
        logic [DIG_W-1:0] r;
        r = d;
`ifdef LEADING_ZERO_BLANK_EN
        begin
            logic lead;
            lead = 1'b1;
            for (int k = NUM_DIGITS - 1; k > 0; k--) begin
                if (lead && (d[4*k +: 4] == 4'h0)) begin
                    r[4*k +: 4] = 4'hF;
                end else if (d[4*k +: 4] != 4'hF) begin
                    lead = 1'b0;
                end
            end
        end
`endif
        return r;
    endfunction

    // Next-state: prescaler, slot index, load buffering and output drive
    always_comb begin
        slot_end  = (cnt_q == CNT_MAX);
        frame_end = slot_end && (idx_q == IDX_LAST);

        cnt_d = slot_end ? '0 : cnt_q + 1'b1;
        idx_d = idx_q;
        if (slot_end) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end

        pend_dig_d   = pend_dig_q;
        pend_dp_d    = pend_dp_q;
        pend_valid_d = pend_valid_q;
        disp_dig_d   = disp_dig_q;
        disp_dp_d    = disp_dp_q;

        if (frame_end && load) begin
            // A load in the boundary cycle bypasses the pending buffer
            disp_dig_d   = lz_blank(digits_in);
            disp_dp_d    = dp_in;
            pend_valid_d = 1'b0;
        end else if (load) begin
            pend_dig_d   = digits_in;
            pend_dp_d    = dp_in;
            pend_valid_d = 1'b1;
        end else if (frame_end && pend_valid_q) begin
            disp_dig_d   = lz_blank(pend_dig_q);
            disp_dp_d    = pend_dp_q;
            pend_valid_d = 1'b0;
        end

        // Outputs track the post-edge slot position and display contents
        if (cnt_d < CNT_GRD) begin
            an_d   = '1;
            bcd_d  = 4'hF;
            dp_n_d = 1'b1;
        end else begin
            an_d   = ~(NUM_DIGITS'(1) << idx_d);
            bcd_d  = disp_dig_d[{idx_d, 2'b00} +: 4];
            dp_n_d = ~disp_dp_d[idx_d];
        end
    end

    // State and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            pend_dig_q   <= ALL_BLANK;
            pend_dp_q    <= '0;
            pend_valid_q <= 1'b0;
            disp_dig_q   <= ALL_BLANK;
            disp_dp_q    <= '0;
            bcd_q        <= 4'hF;
            an_q         <= '1;
            dp_n_q       <= 1'b1;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            pend_dig_q   <= pend_dig_d;
            pend_dp_q    <= pend_dp_d;
            pend_valid_q <= pend_valid_d;
            disp_dig_q   <= disp_dig_d;
            disp_dp_q    <= disp_dp_d;
            bcd_q        <= bcd_d;
            an_q         <= an_d;
            dp_n_q       <= dp_n_d;
        end
    end

    assign bcd_out    = bcd_q;
    assign an         = an_q;
    assign dp_n       = dp_n_q;
    assign digit_idx  = idx_q;
    assign frame_done = frame_end;

endmodule

`default_nettype wire

// File: tb/tb_seg_scan_mux.sv
// ============================================================================
//  Module      : tb_seg_scan_mux
//  Description : Scoreboard bench for seg_scan_mux (4 digits, PRESCALE=4,
//                GUARD=1). A frame-level reference model predicts every cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seg_scan_mux;

    localparam int ND    = 4;
    localparam int PRE   = 4;
    localparam int GRD   = 1;
    localparam int FRAME = ND * PRE;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] digits_in;
    logic [3:0]  dp_in;
    logic        load;
    logic [3:0]  bcd_out;
    logic [3:0]  an;
    logic        dp_n;
    logic [1:0]  digit_idx;
    logic        frame_done;

    seg_scan_mux #(.NUM_DIGITS(ND), .PRESCALE(PRE), .GUARD(GRD)) dut (
        .clk        (clk),
        .reset      (reset),
        .digits_in  (digits_in),
        .dp_in      (dp_in),
        .load       (load),
        .bcd_out    (bcd_out),
        .an         (an),
        .dp_n       (dp_n),
        .digit_idx  (digit_idx),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] an;
        logic [3:0] bcd;
        logic       dpn;
        logic [1:0] idx;
        logic       fd;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference model state: what is on the display, and what waits for the next frame
    logic [15:0] shown_dig;
    logic [3:0]  shown_dp;
    logic [15:0] pend_dig;
    logic [3:0]  pend_dp;
    logic        pend_v;
    int          t;

    function automatic void chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s at t=%0d: actual=%0h required=%0h", name, t, act, req);
        end
    endfunction

    // Blank zeros above the most significant non-zero, non-blank digit
    function automatic logic [15:0] lz(input logic [15:0] d);
        logic [15:0] r;
        r = d;
`ifdef LEADING_ZERO_BLANK_EN
        begin
            int hi;
            hi = 0;
            for (int k = 0; k < ND; k++)
                if (d[k*4 +: 4] != 4'h0 && d[k*4 +: 4] != 4'hF) hi = k;
            for (int k = hi + 1; k < ND; k++)
                if (d[k*4 +: 4] == 4'h0) r[k*4 +: 4] = 4'hF;
        end
`endif
        return r;
    endfunction

    // Monitor: compare every presented cycle against the scoreboard head
    exp_t mon_e;
    always @(negedge clk) begin
        if (!reset && q.size() > 0) begin
            mon_e = q.pop_front();
            chk("an",         int'(an),         int'(mon_e.an));
            chk("bcd_out",    int'(bcd_out),    int'(mon_e.bcd));
            chk("dp_n",       int'(dp_n),       int'(mon_e.dpn));
            chk("digit_idx",  int'(digit_idx),  int'(mon_e.idx));
            chk("frame_done", int'(frame_done), int'(mon_e.fd));
        end
    end

    function automatic exp_t predict(input int tt);
        exp_t e;
        int   c, s;
        c     = tt % PRE;
        s     = (tt / PRE) % ND;
        e.fd  = ((tt % FRAME) == FRAME - 1);
        e.idx = 2'(s);
        if (c < GRD) begin
            e.an  = 4'hF;
            e.bcd = 4'hF;
            e.dpn = 1'b1;
        end else begin
            e.an  = ~(4'b0001 << s);
            e.bcd = shown_dig[s*4 +: 4];
            e.dpn = ~shown_dp[s];
        end
        return e;
    endfunction

    // One cycle: new frame takes pending data, predict, drive, advance
    task automatic step(input logic ld, input logic [15:0] d, input logic [3:0] p);
        if ((t % FRAME) == 0 && pend_v) begin
            shown_dig = lz(pend_dig);
            shown_dp  = pend_dp;
            pend_v    = 1'b0;
        end
        q.push_back(predict(t));
        load      = ld;
        digits_in = d;
        dp_in     = p;
        if (ld) begin
            pend_dig = d;
            pend_dp  = p;
            pend_v   = 1'b1;
        end
        @(posedge clk);
        #1;
        t++;
    endtask

    task automatic rand_step();
        logic ld;
        if ((t % FRAME) == FRAME - 1) ld = ($urandom % 3) == 0;
        else                          ld = ($urandom % 8) == 0;
        step(ld, 16'($urandom), 4'($urandom));
    endtask

    task automatic model_reset();
        shown_dig = 16'hFFFF;
        shown_dp  = 4'h0;
        pend_dig  = 16'hFFFF;
        pend_dp   = 4'h0;
        pend_v    = 1'b0;
        t         = 0;
    endtask

    initial begin
        reset     = 1'b1;
        load      = 1'b0;
        digits_in = 16'h0;
        dp_in     = 4'h0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // Directed frames: idle, deferred load, boundary load, last-load-wins
        for (int f = 0; f < 6; f++) begin
            for (int o = 0; o < FRAME; o++) begin
                if (f == 2 && o == 3)        step(1'b1, 16'h1234, 4'b0010);
                else if (f == 3 && o == 15)  step(1'b1, 16'h5678, 4'b0000);
                else if (f == 4 && o == 2)   step(1'b1, 16'h1111, 4'b1111);
                else if (f == 4 && o == 9)   step(1'b1, 16'h9999, 4'b0001);
                else                         step(1'b0, 16'hAAAA, 4'b0101);
            end
        end

        // Leading-zero patterns, then random traffic
        for (int o = 0; o < FRAME; o++) step(o == 4, 16'h0042, 4'b0100);
        for (int o = 0; o < FRAME; o++) step(o == 4, 16'h0000, 4'b0000);
        for (int o = 0; o < FRAME; o++) step(o == 4, 16'h0F05, 4'b1000);
        for (int n = 0; n < 24 * FRAME; n++) rand_step();

        // Reset mid-frame at slot 2, cnt 2, with a load pending
        for (int o = 0; o < 10; o++) step(o == 1, 16'h7654, 4'b1111);
        q.push_back(predict(t));
        load = 1'b0;
        @(negedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("rst_an",         int'(an),         4'hF);
        chk("rst_bcd_out",    int'(bcd_out),    4'hF);
        chk("rst_digit_idx",  int'(digit_idx),  0);
        chk("rst_dp_n",       int'(dp_n),       1);
        chk("rst_frame_done", int'(frame_done), 0);
        q.delete();
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Post-reset: pending data must be gone, then more random traffic
        for (int o = 0; o < 2 * FRAME; o++) step(1'b0, 16'h3333, 4'hF);
        for (int n = 0; n < 20 * FRAME; n++) rand_step();

        repeat (2) @(negedge clk);
        chk("scoreboard_drained", q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Hard time limit so the run always terminates
    initial begin
        #2000000;
        $display("FAIL timeout: actual=running required=finished");
        $fatal(1);
    end

endmodule

`default_nettype wire

// File: doc/seg_scan_mux.md
Name: seg_scan_mux

Overview:
- Time-multiplexing scanner that sits directly upstream of the BCD-to-7-segment decoder on the FPGA board's common-anode multi-digit display.
- Holds NUM_DIGITS BCD digits plus decimal points.
- Presents one digit at a time on bcd_out to the decoder and drives the matching active-low anode enable.
- Inserts a dark guard interval between digits to prevent ghosting.
- Applies new display data only at frame boundaries, so digits never tear.

Parameters:
- NUM_DIGITS, 4, number of display digits (2..8).
- PRESCALE, 100000, clk cycles per digit slot (>=2).
- GUARD, 2000, cycles at the start of each slot with all anodes off (0 <= GUARD < PRESCALE).

Ports:
- clk  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-high reset.
- digits_in  in  4*NUM_DIGITS  BCD digits; digit 0 (least significant) = [3:0].
- dp_in  in  NUM_DIGITS  decimal point per digit, 1 = lit.
- load  in  1  one-cycle strobe; captures digits_in/dp_in.
- bcd_out  out  4  current digit to the decoder; 4'hF = blank (decoder default turns all segments off).
- an  out  NUM_DIGITS  anode enables, active-low.
- dp_n  out  1  decimal point segment, active-low.
- digit_idx  out  clog2(NUM_DIGITS)  index of the slot being scanned.
- frame_done  out  1  one-cycle pulse in the last cycle of a frame.

Behaviour:
- Reset (async assert, sync-to-clk deassert is not required):
  - an = all 1s, bcd_out = 4'hF, dp_n = 1, digit_idx = 0, frame_done = 0.
  - Prescale counter cnt = 0.
  - Pending and display registers = all 4'hF digits, dp = 0.
  - pend_valid = 0.
- Counters:
  - cnt counts 0..PRESCALE-1 every cycle, then wraps to 0.
  - When cnt == PRESCALE-1, digit_idx increments on the next edge and wraps NUM_DIGITS-1 -> 0.
- Frame boundary: cnt == PRESCALE-1 and digit_idx == NUM_DIGITS-1. frame_done = 1 in exactly that cycle (combinational from state).
- Load path:
  - load = 1 captures digits_in/dp_in into the pending register and sets pend_valid.
  - At a frame boundary with pend_valid = 1, pending copies into the display register and pend_valid clears.
  - load in a boundary cycle: the new digits_in go straight to the display register; pend_valid stays 0.
  - Multiple loads within one frame: the last load wins.
- Outputs are registered and reflect the post-edge state (idx, cnt):
  - cnt < GUARD: an = all 1s, dp_n = 1, bcd_out = 4'hF.
  - Otherwise: an = ~(1 << idx), bcd_out = display digit[idx], dp_n = ~display dp[idx].
- Exactly zero or one bit of an is low in any cycle.
- Digit values 10..15 pass through unchanged; the decoder blanks them.
- Reset asserted mid-frame returns all state to the reset values immediately; pending data is discarded.
- GUARD = 0: no dark interval; anode switches on the slot's first cycle.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined:
  - When a digit is copied into the display register, each digit k > 0 whose value is 0 and whose higher digits are all 0 or blank is stored as 4'hF; digit 0 is never blanked.
  - The dp of a blanked digit is still honoured.
  - Example: 0,0,4,2 displays as blank,blank,4,2.
- Undefined: digits are displayed exactly as loaded.

Test Plan (NUM_DIGITS=4, PRESCALE=4, GUARD=1; frame = 16 cycles):
- Reset release, no load -> an = 4'b1111 in cnt=0 cycles; an walks 1110, 1101, 1011, 0111 for 3 cycles each; bcd_out = 4'hF throughout; frame_done high on cycles 15, 31.
- load digits_in = 16'h1234, dp_in = 4'b0010 at cycle 3 -> unchanged until after cycle 15; next frame bcd_out = 4, 3, 2, 1 on an = 1110, 1101, 1011, 0111; dp_n = 0 only during the an = 1101 slot.
- load 16'h5678 coincident with frame_done -> shown in the immediately following frame.
- load 16'h1111 then 16'h9999 in the same frame -> next frame shows only 9,9,9,9.
- reset asserted at cnt=2 of slot 2 -> same cycle an = 1111, bcd_out = F, digit_idx = 0; scan restarts from slot 0 with blank digits.
- With LEADING_ZERO_BLANK_EN, load 16'h0042 -> bcd_out = 2, 4, F, F; load 16'h0000 -> 0, F, F, F.
